spi_burst_seq: RTL

- Byte-burst sequencer that sits directly upstream of the single-CS SPI master.
- A CPU-side register interface fills a TX byte buffer, programs a length, and pulses start.
- The block feeds the SPI master one byte at a time with the required TX handshake, counts and stores every returned MISO byte into an RX buffer, and signals completion.

---
 rtl/spi_burst_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_burst_seq.sv
// Byte-burst sequencer feeding a single-CS SPI master: issues TX bytes from a
// CPU-filled buffer with the master's DV/ready handshake and captures MISO bytes.
module spi_burst_seq #(
    parameter  int unsigned MAX_BYTES = 8,
    localparam int unsigned CW        = $clog2(MAX_BYTES + 1),
    localparam int unsigned AW        = $clog2(MAX_BYTES)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Wr_En,
    input  logic [AW-1:0] i_Wr_Addr,
    input  logic [7:0]    i_Wr_Data,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data,
    input  logic [CW-1:0] i_Len,
    input  logic          i_Start,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Err,
    output logic [CW-1:0] o_TX_Count,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte
);

    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(MAX_BYTES);
    localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tx_idx, tx_idx_nxt;
    logic [CW-1:0] rx_idx, rx_idx_nxt;
    logic          busy_nxt, done_nxt, err_nxt, dv_nxt;
    logic [7:0]    byte_nxt;
    logic [CW-1:0] count_nxt;

    logic [7:0]    txbuf [MAX_BYTES];
    logic [7:0]    rxbuf [MAX_BYTES];

    logic          wr_ok;
    logic          rx_we;
    logic          len_ok;

    assign wr_ok  = i_Wr_En && !o_Busy && ({1'b0, i_Wr_Addr} < ADDR_LIM);
    assign rx_we  = o_Busy && i_RX_DV && (rx_idx < o_TX_Count);
    assign len_ok = (i_Len != '0) && (i_Len <= LEN_MAX);

    assign o_Rd_Data = ({1'b0, i_Rd_Addr} < ADDR_LIM) ? rxbuf[i_Rd_Addr] : 8'h00;

    // CPU-side TX buffer; frozen while a burst is running
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) txbuf[i] <= 8'h00;
        end else if (wr_ok) begin
            txbuf[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) rxbuf[i] <= 8'h00;
        end else if (rx_we) begin
            rxbuf[AW'(rx_idx)] <= i_RX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_idx     <= '0;
            rx_idx     <= '0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_Err      <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= 8'h00;
            o_TX_Count <= '0;
        end else begin
            tx_idx     <= tx_idx_nxt;
            rx_idx     <= rx_idx_nxt;
            o_Busy     <= busy_nxt;
            o_Done     <= done_nxt;
            o_Err      <= err_nxt;
            o_TX_DV    <= dv_nxt;
            o_TX_Byte  <= byte_nxt;
            o_TX_Count <= count_nxt;
        end
    end

    // RX capture runs in every busy state, alongside the issue path
    always_comb begin
        state_nxt  = state;
        tx_idx_nxt = tx_idx;
        rx_idx_nxt = rx_idx;
        busy_nxt   = o_Busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        dv_nxt     = 1'b0;
        byte_nxt   = o_TX_Byte;
        count_nxt  = o_TX_Count;

        if (rx_we) rx_idx_nxt = rx_idx + CW'(1);

        case (state)
            S_IDLE: begin
                if (i_Start) begin
                    if (len_ok) begin
                        count_nxt  = i_Len;
                        tx_idx_nxt = '0;
                        rx_idx_nxt = '0;
                        busy_nxt   = 1'b1;
                        state_nxt  = S_WAIT_RDY;
                    end else begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (tx_idx == o_TX_Count) begin
                    state_nxt = S_DRAIN;
                end else if (i_TX_Ready) begin
                    dv_nxt     = 1'b1;
                    byte_nxt   = txbuf[AW'(tx_idx)];
                    tx_idx_nxt = tx_idx + CW'(1);
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_GAP;
            // ready from the master is stale here, so it is not looked at
            S_GAP:   state_nxt = S_WAIT_RDY;
            S_DRAIN: begin
                if (rx_idx == o_TX_Count) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
